// File: rtl/adder_pkg.sv
// Shared definitions for the adder/subtractor family: FSM encoding and default datapath sizes.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/borrow_lookahead_subtractor_seq_bla_slice.sv
// Combinational borrow slice: d = a - b - bin over SLICE bits, with the borrow out of the top bit.
module bla_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic             bw;

  // A borrow is generated where a=0,b=1 and passes through where the two bits are equal.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  always_comb begin
    bw = bin;
    d  = '0;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = a[i] ^ b[i] ^ bw;
      bw   = g[i] | (p[i] & bw);
    end
  end

  assign bout = bw;

endmodule

// File: rtl/borrow_lookahead_subtractor_seq.sv
// Multi-cycle subtractor D = A - B - Bin: one SLICE-bit chunk per cycle, LSB first, with the
// inter-chunk borrow held in a register; valid/ready handshakes on both sides.
module borrow_lookahead_subtractor_seq
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned NSL  = WIDTH / SLICE;
  localparam int unsigned IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("WIDTH must be an integer multiple of SLICE");
  end

  typedef logic [NSL-1:0][SLICE-1:0] word_t;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  word_t           a_q, a_d;
  word_t           b_q, b_d;
  word_t           d_q, d_d;
  logic            bw_q, bw_d;
  logic            bout_q, bout_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;

  logic [SLICE-1:0] sl_d;
  logic             sl_bout;

  bla_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .bin  (bw_q),
    .d    (sl_d),
    .bout (sl_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      bw_q        <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      bw_q        <= bw_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    d_d         = d_q;
    bw_d        = bw_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          bw_d    = Bin;
          idx_d   = '0;
        end
      end
      RUN: begin
        d_d[idx_q] = sl_d;
        bw_d       = sl_bout;
        idx_d      = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // Last chunk: its top bit is the result MSB, so overflow is decided here.
          idx_d       = '0;
          bout_d      = sl_bout;
          ovf_d       = (a_q[NSL-1][SLICE-1] != b_q[NSL-1][SLICE-1]) &&
                        (sl_d[SLICE-1] != a_q[NSL-1][SLICE-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign Ovf       = ovf_q;

endmodule
